// File: rtl/prod_accum_relu.sv
// rtl/prod_accum_relu.sv - sums NUM_TERMS signed products, adds bias, shifts, clamps (ReLU + saturate)
module prod_accum_relu #(
  parameter int IN_WIDTH  = 13,
  parameter int NUM_TERMS = 8,
  parameter int ACC_WIDTH = 17,
  parameter int BIAS      = 16,
  parameter int SHIFT     = 4,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_sat
);

  localparam int CW = $clog2(NUM_TERMS);
  // Activation arithmetic runs wide enough that both s and the clamp limit fit with sign.
  localparam int SW = ((ACC_WIDTH > OUT_WIDTH) ? ACC_WIDTH : OUT_WIDTH) + 2;
  localparam logic [CW-1:0] LAST = CW'(NUM_TERMS - 1);
  localparam logic signed [ACC_WIDTH:0] BIAS_X = $signed((ACC_WIDTH+1)'(BIAS));
  localparam logic signed [SW-1:0] MAXV = {{(SW-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic signed [ACC_WIDTH-1:0] acc;
  logic [CW-1:0]               cnt;
  logic                        accept;
  logic                        last_beat;

  logic signed [ACC_WIDTH:0]   acc_ext;
  logic signed [ACC_WIDTH:0]   in_ext;
  logic signed [ACC_WIDTH:0]   sum_beat;
  logic signed [ACC_WIDTH:0]   s;
  logic signed [SW-1:0]        s_ext;
  logic signed [SW-1:0]        r;
  logic [OUT_WIDTH-1:0]        act_data;
  logic                        act_sat;

  assign in_ready  = (state == ACC);
  assign out_valid = (state == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACC;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_beat = 1'b0;
    case (state)
      ACC: begin
        if (in_valid) begin
          accept = 1'b1;
          if (cnt == LAST) begin
            last_beat = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt = ACC;
        end
      end
      default: state_nxt = ACC;
    endcase
  end

  assign acc_ext  = {acc[ACC_WIDTH-1], acc};
  assign in_ext   = {{(ACC_WIDTH+1-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
  assign sum_beat = acc_ext + in_ext;
  assign s        = sum_beat + BIAS_X;
  assign s_ext    = {{(SW-ACC_WIDTH-1){s[ACC_WIDTH]}}, s};
  assign r        = s_ext >>> SHIFT;

  always_comb begin
    act_data = '0;
    act_sat  = 1'b0;
    if (s[ACC_WIDTH]) begin
      act_data = '0;
    end else if (r > MAXV) begin
      act_data = '1;
      act_sat  = 1'b1;
    end else begin
      act_data = r[OUT_WIDTH-1:0];
    end
  end

  // Result registers only move on the final beat, so they persist across the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      cnt      <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else if (accept) begin
      if (last_beat) begin
        acc      <= '0;
        cnt      <= '0;
        out_data <= act_data;
        out_sat  <= act_sat;
      end else begin
        acc <= sum_beat[ACC_WIDTH-1:0];
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_prod_accum_relu.sv
// tb/tb_prod_accum_relu.sv - randomized self-checking bench for prod_accum_relu
module tb_prod_accum_relu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [12:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_sat;

  int checks = 0;
  int errors = 0;
  bit compare_on = 1'b0;

  // Reference: list of accepted products, result computed from the whole list.
  int beats[$];
  bit m_hold = 1'b0;
  int m_data = 0;
  bit m_sat  = 1'b0;

  prod_accum_relu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_result();
    int s;
    int r;
    s = 16;
    foreach (beats[i]) s += beats[i];
    if (s < 0) begin
      m_data = 0;
      m_sat  = 1'b0;
    end else begin
      r = s / 16;
      if (r > 255) begin
        m_data = 255;
        m_sat  = 1'b1;
      end else begin
        m_data = r;
        m_sat  = 1'b0;
      end
    end
  endfunction

  always @(negedge rst_n) begin
    beats.delete();
    m_hold = 1'b0;
    m_data = 0;
    m_sat  = 1'b0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (m_hold) begin
        if (out_ready) m_hold = 1'b0;
      end else if (in_valid) begin
        beats.push_back(int'($signed(in_data)));
        if (beats.size() == 8) begin
          model_result();
          beats.delete();
          m_hold = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (compare_on) begin
      chk("in_ready", int'(in_ready), int'(!m_hold));
      chk("out_valid", int'(out_valid), int'(m_hold));
      chk("out_data", int'(out_data), m_data);
      chk("out_sat", int'(out_sat), int'(m_sat));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beats(input int val, input int n, input bit bubbles);
    int got;
    got = 0;
    in_data = 13'(val);
    while (got < n) begin
      in_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
      if (in_valid) got++;
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic expect_result(input string name, input int exp_data, input int exp_sat);
    int waited;
    waited = 0;
    while (!out_valid && waited < 20) begin
      step();
      waited++;
    end
    chk({name, "_latency"}, waited, 0);
    chk({name, "_data"}, int'(out_data), exp_data);
    chk({name, "_sat"}, int'(out_sat), exp_sat);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic pulse_reset(input string name);
    #1;
    rst_n = 1'b0;
    #1;
    chk({name, "_rst_out_valid"}, int'(out_valid), 0);
    chk({name, "_rst_in_ready"}, int'(in_ready), 1);
    chk({name, "_rst_out_data"}, int'(out_data), 0);
    chk({name, "_rst_out_sat"}, int'(out_sat), 0);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #3;
    chk("por_out_valid", int'(out_valid), 0);
    chk("por_in_ready", int'(in_ready), 1);
    chk("por_out_data", int'(out_data), 0);
    #9;
    rst_n = 1'b1;
    compare_on = 1'b1;
    step();

    // 800 + 16 = 816, >>4 = 51
    drive_beats(100, 8, 1'b1);
    expect_result("nominal", 51, 0);

    // Backpressure: result held, pending beats ignored.
    in_valid = 1'b1;
    in_data  = 13'd7;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_data", int'(out_data), 51);
    end
    in_valid = 1'b0;
    handshake();
    chk("bp_release_in_ready", int'(in_ready), 1);
    chk("bp_retained_data", int'(out_data), 51);
    // 8 + 16 = 24, >>4 = 1
    drive_beats(1, 8, 1'b0);
    expect_result("after_bp", 1, 0);
    handshake();

    // -32768 + 16 = -32752 -> clamp to 0
    drive_beats(-4096, 8, 1'b1);
    expect_result("neg_clamp", 0, 0);
    handshake();

    // 32760 + 16 = 32776, >>4 = 2048 -> saturate
    drive_beats(4095, 8, 1'b0);
    expect_result("saturate", 255, 1);

    pulse_reset("hold");
    step();

    drive_beats(1000, 3, 1'b0);
    pulse_reset("midacc");
    step();
    drive_beats(1, 8, 1'b0);
    expect_result("after_reset", 1, 0);
    handshake();

    for (int c = 0; c < 3000; c++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      in_data   = 13'($urandom_range(0, 8191));
      if ($urandom_range(0, 7) == 0) in_data = 13'h1000;
      out_ready = 1'($urandom_range(0, 2) == 0);
      if (c == 1500) pulse_reset("random");
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
